// File: rtl/shared_resource_responder.sv
// shared_resource_responder: round-robin arbitrated fixed-latency compute resource shared by two pipelines.
module shared_resource_responder #(
    parameter int          DATA_W  = 32,
    parameter int          LATENCY = 3,
    parameter int unsigned INCR    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              global_stall,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              in_flush_1,
    input  logic              in_flush_2,
    output logic              out_valid_1,
    output logic              out_valid_2,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic              out_flush_1,
    output logic              out_flush_2,
    output logic              out_stall_1,
    output logic              out_stall_2
);
    localparam int LAST = LATENCY - 1;
    localparam logic [DATA_W-1:0] INC = DATA_W'(INCR);

    logic [1:0]        slot_v_q, slot_v_d;
    logic [DATA_W-1:0] slot_dat_q [2];
    logic [DATA_W-1:0] slot_dat_d [2];
    logic [LATENCY-1:0] stg_v_q, stg_v_d, stg_id_q, stg_id_d;
    logic [DATA_W-1:0] stg_r_q [LATENCY];
    logic [DATA_W-1:0] stg_r_d [LATENCY];
    logic              last2_q, last2_d;
    logic [1:0]        ack_q;
    logic [1:0]        vld, fl, grant, stall, acc;

    assign vld = {in_valid_2, in_valid_1};
    assign fl  = {in_flush_2, in_flush_1};

    always_comb begin
        grant[0] = ~global_stall & slot_v_q[0] & (~slot_v_q[1] | last2_q);
        grant[1] = ~global_stall & slot_v_q[1] & (~slot_v_q[0] | ~last2_q);
        stall = {2{global_stall}} | (slot_v_q & ~grant);
        acc = vld & ~stall & ~fl;
        slot_v_d = acc | (slot_v_q & ~grant & ~fl);
        slot_dat_d[0] = acc[0] ? in_data_1 : slot_dat_q[0];
        slot_dat_d[1] = acc[1] ? in_data_2 : slot_dat_q[1];
        last2_d = (&slot_v_q & |grant) ? grant[1] : last2_q;
        stg_v_d = stg_v_q;
        stg_id_d = stg_id_q;
        stg_r_d = stg_r_q;
        if (!global_stall) begin
            stg_v_d[0] = |grant;
            stg_id_d[0] = grant[1];
            stg_r_d[0] = (grant[1] ? slot_dat_q[1] : slot_dat_q[0]) + INC;
            for (int j = 1; j < LATENCY; j++) begin
                stg_v_d[j] = stg_v_q[j-1];
                stg_id_d[j] = stg_id_q[j-1];
                stg_r_d[j] = stg_r_q[j-1];
            end
        end
        // flush kills by tag after the shift, so a same-edge grant of the flushed slot also dies
        for (int j = 0; j < LATENCY; j++) stg_v_d[j] = stg_v_d[j] & ~fl[stg_id_d[j]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v_q <= '0;
            slot_dat_q <= '{default: '0};
            stg_v_q <= '0;
            stg_id_q <= '0;
            stg_r_q <= '{default: '0};
            last2_q <= 1'b1;
            ack_q <= '0;
        end else begin
            slot_v_q <= slot_v_d;
            slot_dat_q <= slot_dat_d;
            stg_v_q <= stg_v_d;
            stg_id_q <= stg_id_d;
            stg_r_q <= stg_r_d;
            last2_q <= last2_d;
            ack_q <= fl;
        end
    end

    assign out_valid_1 = stg_v_q[LAST] & ~stg_id_q[LAST];
    assign out_valid_2 = stg_v_q[LAST] & stg_id_q[LAST];
    assign out_data_1  = out_valid_1 ? stg_r_q[LAST] : '0;
    assign out_data_2  = out_valid_2 ? stg_r_q[LAST] : '0;
    assign out_flush_1 = ack_q[0];
    assign out_flush_2 = ack_q[1];
    assign out_stall_1 = stall[0];
    assign out_stall_2 = stall[1];
endmodule

// File: tb/tb_shared_resource_responder.sv
// tb_shared_resource_responder: table-driven directed check of the shared resource responder.
module tb_shared_resource_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, global_stall, in_valid_1, in_valid_2, in_flush_1, in_flush_2;
  logic [31:0] in_data_1, in_data_2, out_data_1, out_data_2;
  logic out_valid_1, out_valid_2, out_flush_1, out_flush_2, out_stall_1, out_stall_2;
  shared_resource_responder dut (
    .clk(clk), .reset(reset), .global_stall(global_stall),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_flush_1(in_flush_1), .in_flush_2(in_flush_2),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_flush_1(out_flush_1), .out_flush_2(out_flush_2),
    .out_stall_1(out_stall_1), .out_stall_2(out_stall_2)
  );
  typedef struct {
    logic rst, gs, v1, v2, f1, f2;
    logic [31:0] d1, d2;
    logic ev1, ev2, ef1, ef2, es1, es2;
    logic [31:0] ed1, ed2;
  } vec_t;
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  logic got;
  task automatic add(input logic rst, gs, v1, input logic [31:0] d1, input logic v2,
                     input logic [31:0] d2, input logic f1, f2, ev1, input logic [31:0] ed1,
                     input logic ev2, input logic [31:0] ed2, input logic ef1, ef2, es1, es2);
    vec_t v;
    v.rst = rst; v.gs = gs; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.f1 = f1; v.f2 = f2;
    v.ev1 = ev1; v.ed1 = ed1; v.ev2 = ev2; v.ed2 = ed2;
    v.ef1 = ef1; v.ef2 = ef2; v.es1 = es1; v.es2 = es2;
    vecs.push_back(v);
  endtask
  task automatic z(input int n);
    repeat (n) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rs();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rs();
    add(0, 0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z(3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11, 0, 0, 0, 0, 0, 0);
    z(1);
    rs();
    add(0, 0, 1, 'hA, 1, 'hB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    z(2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hB, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hC, 0, 0, 0, 0);
    z(1);
    rs();
    for (int k = 1; k <= 12; k++)
      add(0, 0, k <= 8, k, 0, 0, 0, 0, k >= 5, k >= 5 ? k - 3 : 0, 0, 0, 0, 0, 0, 0);
    z(1);
    rs();
    add(0, 0, 1, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    z(3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h21, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z(3);
    repeat (2) add(0, 1, 0, 0, 0, 0, 0, 0, 1, 'h31, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h31, 0, 0, 0, 0, 0, 0);
    z(1);
    rs();
    add(0, 0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z(1);
    add(0, 0, 1, 'h99, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h51, 0, 0, 0, 0);
    z(3);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    z(1);
    rs();
    add(0, 0, 1, 'h60, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h70, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z(1);
    rs();
    z(5);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; global_stall = vecs[i].gs;
      in_valid_1 = vecs[i].v1; in_data_1 = vecs[i].d1;
      in_valid_2 = vecs[i].v2; in_data_2 = vecs[i].d2;
      in_flush_1 = vecs[i].f1; in_flush_2 = vecs[i].f2;
      @(negedge clk);
      if (!vecs[i].rst) begin
        checks++;
        if ({out_valid_1, out_data_1, out_valid_2, out_data_2, out_flush_1, out_flush_2, out_stall_1, out_stall_2} !==
            {vecs[i].ev1, vecs[i].ed1, vecs[i].ev2, vecs[i].ed2, vecs[i].ef1, vecs[i].ef2, vecs[i].es1, vecs[i].es2}) begin
          errors++;
          $display("FAIL row %0d: got v1=%b d1=%h v2=%b d2=%h fl=%b%b st=%b%b, expected v1=%b d1=%h v2=%b d2=%h fl=%b%b st=%b%b",
                   i, out_valid_1, out_data_1, out_valid_2, out_data_2, out_flush_1, out_flush_2,
                   out_stall_1, out_stall_2, vecs[i].ev1, vecs[i].ed1, vecs[i].ev2, vecs[i].ed2,
                   vecs[i].ef1, vecs[i].ef2, vecs[i].es1, vecs[i].es2);
        end
      end
      @(posedge clk);
      #1;
    end
    reset = 1; global_stall = 0; in_valid_1 = 0; in_valid_2 = 0; in_flush_1 = 0; in_flush_2 = 0;
    in_data_1 = 0; in_data_2 = 0;
    @(posedge clk);
    #1;
    reset = 0;
    checks++;
    if ({out_valid_1, out_data_1, out_valid_2, out_data_2, out_flush_1, out_flush_2, out_stall_1, out_stall_2} !== '0) begin
      errors++;
      $display("FAIL reset state: v1=%b d1=%h v2=%b d2=%h fl=%b%b st=%b%b", out_valid_1, out_data_1,
               out_valid_2, out_data_2, out_flush_1, out_flush_2, out_stall_1, out_stall_2);
    end
    in_valid_1 = 1; in_data_1 = 'h80;
    @(posedge clk);
    #1;
    in_valid_1 = 0; in_data_1 = 0;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (out_valid_1) got = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout: out_valid_1 never asserted for request 0x80");
    end else if (out_data_1 !== 32'h81) begin
      errors++;
      $display("FAIL wait result: got d1=%h expected 81", out_data_1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
